// File: rtl/calc_controller.sv
// calc_controller: keypad-event to datapath-strobe control FSM for the
// four-bit calculator. Every output is registered; strobes are one-cycle
// pulses and the data/select outputs hold between updates.
module calc_controller #(
   parameter int unsigned NUM_W = 4,
   parameter int unsigned OP_W  = 3
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             key_digit_valid,
   input  logic [NUM_W-1:0] key_digit,
   input  logic             key_op_valid,
   input  logic [OP_W-1:0]  key_op,
   input  logic             key_eq,
   input  logic             key_clr,
   output logic             load_number,
   output logic             clear_number,
   output logic [NUM_W-1:0] inputRegD,
   output logic             inSelect,
   output logic             load_result,
   output logic             clear_result,
   output logic             load_code,
   output logic             clear_code,
   output logic [OP_W-1:0]  OpCode,
   output logic             sel_display,
   output logic             busy,
   output logic             key_drop
);

   typedef enum logic [2:0] {StA, StOp, StB, StChain, StRes} stateT;

   stateT            stateQ, stateD;
   logic [OP_W-1:0]  pendOpQ, pendOpD;

   logic             loadNumberD, clearNumberD;
   logic             loadResultD, clearResultD;
   logic             loadCodeD, clearCodeD;
   logic [NUM_W-1:0] inputRegDD;
   logic [OP_W-1:0]  opCodeD;
   logic             inSelectD, selDisplayD, busyD, keyDropD;

   // Next state and next registered outputs; key priority clr > eq > op > digit.
   always_comb begin
      stateD       = stateQ;
      pendOpD      = pendOpQ;
      loadNumberD  = 1'b0;
      clearNumberD = 1'b0;
      loadResultD  = 1'b0;
      clearResultD = 1'b0;
      loadCodeD    = 1'b0;
      clearCodeD   = 1'b0;
      keyDropD     = 1'b0;
      inputRegDD   = inputRegD;
      opCodeD      = OpCode;
      inSelectD    = inSelect;
      selDisplayD  = sel_display;

      if (key_clr) begin
         // Also aborts a pending chained load_code.
         clearNumberD = 1'b1;
         clearResultD = 1'b1;
         clearCodeD   = 1'b1;
         selDisplayD  = 1'b0;
         stateD       = StA;
      end else begin
         case (stateQ)
            StChain: begin
               // Second half of a chained operator; any key here is lost.
               loadCodeD   = 1'b1;
               opCodeD     = pendOpQ;
               selDisplayD = 1'b1;
               stateD      = StOp;
               keyDropD    = key_eq | key_op_valid | key_digit_valid;
            end
            StA: begin
               if (key_eq) begin
                  // ignored
               end else if (key_op_valid) begin
                  loadResultD = 1'b1;
                  inSelectD   = 1'b0;
                  loadCodeD   = 1'b1;
                  opCodeD     = key_op;
                  selDisplayD = 1'b1;
                  stateD      = StOp;
               end else if (key_digit_valid) begin
                  loadNumberD = 1'b1;
                  inputRegDD  = key_digit;
                  selDisplayD = 1'b0;
               end
            end
            StOp: begin
               if (key_eq) begin
                  // ignored
               end else if (key_op_valid) begin
                  loadCodeD = 1'b1;
                  opCodeD   = key_op;
               end else if (key_digit_valid) begin
                  loadNumberD = 1'b1;
                  inputRegDD  = key_digit;
                  selDisplayD = 1'b0;
                  stateD      = StB;
               end
            end
            StB: begin
               if (key_eq) begin
                  loadResultD = 1'b1;
                  inSelectD   = 1'b1;
                  selDisplayD = 1'b1;
                  stateD      = StRes;
               end else if (key_op_valid) begin
                  // ALU still sees the old code this cycle; new code follows.
                  loadResultD = 1'b1;
                  inSelectD   = 1'b1;
                  pendOpD     = key_op;
                  stateD      = StChain;
               end else if (key_digit_valid) begin
                  loadNumberD = 1'b1;
                  inputRegDD  = key_digit;
               end
            end
            StRes: begin
               if (key_eq) begin
                  // ignored
               end else if (key_op_valid) begin
                  // Accumulator becomes operand A.
                  loadCodeD = 1'b1;
                  opCodeD   = key_op;
                  stateD    = StOp;
               end else if (key_digit_valid) begin
                  loadNumberD  = 1'b1;
                  inputRegDD   = key_digit;
                  clearResultD = 1'b1;
                  selDisplayD  = 1'b0;
                  stateD       = StA;
               end
            end
            default: stateD = StA;
         endcase
      end
      busyD = (stateD == StChain);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (clear) begin
         stateQ       <= StA;
         pendOpQ      <= '0;
         load_number  <= 1'b0;
         clear_number <= 1'b1;
         load_result  <= 1'b0;
         clear_result <= 1'b1;
         load_code    <= 1'b0;
         clear_code   <= 1'b1;
         inputRegD    <= '0;
         OpCode       <= '0;
         inSelect     <= 1'b0;
         sel_display  <= 1'b0;
         busy         <= 1'b0;
         key_drop     <= 1'b0;
      end else begin
         stateQ       <= stateD;
         pendOpQ      <= pendOpD;
         load_number  <= loadNumberD;
         clear_number <= clearNumberD;
         load_result  <= loadResultD;
         clear_result <= clearResultD;
         load_code    <= loadCodeD;
         clear_code   <= clearCodeD;
         inputRegD    <= inputRegDD;
         OpCode       <= opCodeD;
         inSelect     <= inSelectD;
         sel_display  <= selDisplayD;
         busy         <= busyD;
         key_drop     <= keyDropD;
      end
   end

endmodule

// File: doc/calc_controller.md
# calc_controller

Control FSM for the four-bit keypad calculator. It converts single-cycle keypad events (digit, operator, equals, clear) into the register load/clear strobes, mux selects and operand/opcode buses that drive the calculator datapath. It sits between the keypad decoder and the datapath, and is the sole driver of every datapath control input.

## Interface
- NUM_W, 4, digit width; drives the input register data bus.
- OP_W, 3, operator code width; passed unchanged to the opcode register.
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous, active-high reset.
- key_digit_valid  in  1  one-cycle pulse; key_digit is valid.
- key_digit  in  NUM_W  digit value 0–15.
- key_op_valid  in  1  one-cycle pulse; key_op is valid.
- key_op  in  OP_W  operator code.
- key_eq  in  1  one-cycle pulse: equals key.
- key_clr  in  1  one-cycle pulse: clear-entry key.
- load_number, clear_number  out  1  input register strobes.
- inputRegD  out  NUM_W  input register data.
- inSelect  out  1  accumulator mux select: 0 = input register (zero-extended), 1 = ALU result.
- load_result, clear_result  out  1  accumulator strobes.
- load_code, clear_code  out  1  opcode register strobes.
- OpCode  out  OP_W  opcode register data.
- sel_display  out  1  display select: 0 = input register, 1 = accumulator.
- busy  out  1  high while keys are not accepted.
- key_drop  out  1  one-cycle pulse when a key arrives while busy.

## Operation
- All outputs are registered. Strobes are one-cycle pulses; inputRegD, OpCode, inSelect and sel_display hold their values between updates.
- States: S_A (entering operand A), S_OP (operator latched, waiting for B), S_B (operand B entered), S_CHAIN (internal, busy), S_RES (result shown).
- Simultaneous key priority: key_clr > key_eq > key_op_valid > key_digit_valid. Only one key is acted on per cycle; lower-priority keys in the same cycle are discarded without setting key_drop.
- key_clr, any state: pulse clear_number, clear_result and clear_code; sel_display=0; go to S_A.
- Digit:
  - S_A: load_number with inputRegD=key_digit (the new digit replaces the old one); sel_display=0.
  - S_OP: load_number; sel_display=0; go to S_B.
  - S_B: load_number; stay in S_B.
  - S_RES: load_number plus clear_result; sel_display=0; go to S_A.
- Operator:
  - S_A: load_result with inSelect=0, and load_code with OpCode=key_op in the same cycle; sel_display=1; go to S_OP.
  - S_OP: load_code only (replaces the operator).
  - S_RES: load_code only; the accumulator is operand A; go to S_OP.
  - S_B: first cycle, load_result with inSelect=1 (ALU uses the old code); latch key_op internally; go to S_CHAIN. Next cycle, load_code with OpCode=latched op; sel_display=1; go to S_OP.
- key_eq:
  - S_B: load_result with inSelect=1; sel_display=1; go to S_RES.
  - S_A, S_OP, S_RES: no strobes (ignored).
- busy=1 only in S_CHAIN. Any key accepted in S_CHAIN except key_clr is dropped, and key_drop pulses. key_clr in S_CHAIN aborts: the load_code is not issued and the clears fire.

## Timing
- Latency: a key sampled at rising edge k drives the strobes high during cycle k+1. The datapath captures at edge k+2.
- Chained operator: load_result in cycle k+1, load_code in cycle k+2. busy is high in cycle k+1 only.
- Reset (clear=1 at an edge): state S_A; clear_number=clear_result=clear_code=1; all load strobes=0; inSelect=0, sel_display=0, inputRegD=0, OpCode=0, busy=0, key_drop=0.
- The clears stay high for every cycle clear is held, plus the first cycle after release, then drop to 0.
- Reset mid-chain: the pending load_code is discarded.
- Strobe exclusivity: load_number and clear_number are never high in the same cycle. The same holds for the result pair and the code pair.

## Test plan
- Reset: hold clear for 3 cycles → clears high through the cycle after release, all other outputs 0, state S_A.
- Sequence digit 3, op 2, digit 5, eq, one key every 4 cycles → pulses in order:
  - load_number (inputRegD=3);
  - load_result (inSelect=0) with load_code (OpCode=2);
  - load_number (inputRegD=5);
  - load_result (inSelect=1), with sel_display=1 at the end.
- Chain: digit 3, op 1, digit 4, op 2 → at the last op, load_result (inSelect=1) in cycle k+1, load_code (OpCode=2) in cycle k+2, busy high for exactly one cycle.
- Busy drop: a digit of 7 applied on the busy cycle → key_drop pulses once, no load_number, inputRegD unchanged.
- Simultaneous key_clr and key_digit_valid (digit 9) in S_B → only the three clears pulse, load_number=0, state S_A.
- Result reuse: after eq, op 4 → load_code only (OpCode=4), no load_result. Then a digit 6 → load_number, with no clear_result.
